// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared constants and state encoding for the systolic array controller
package systolic_pkg;

  localparam int DIM          = 5;
  localparam int FLUSH_CYCLES = 9;
  localparam int SHIFT_CYCLES = 4;
  localparam int MODE_W       = DIM * DIM;

  // Controller state encoding, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_FEED  = 3'd2;
  localparam state_t ST_FLUSH = 3'd3;
  localparam state_t ST_READ  = 3'd4;
  localparam state_t ST_SHIFT = 3'd5;
  localparam state_t ST_DONE  = 3'd6;

endpackage

// File: rtl/skew_line.sv
// rtl/skew_line.sv - zero-reset N-bit delay line of DEPTH registered stages
//
// Ports:
//   clk     clock
//   clr_n   asynchronous active-low reset, clears every stage to zero
//   en_i    shift enable
//   din_i   value entering stage 0
//   dout_o  value leaving the last stage (DEPTH cycles after entry)
module skew_line #(
  parameter int DEPTH = 1,
  parameter int N     = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         en_i,
  input  logic [N-1:0] din_i,
  output logic [N-1:0] dout_o
);

  logic [N-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (en_i) begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// rtl/systolic_ctrl.sv - job sequencer for the 5x5 output-stationary systolic array
//
// Ports:
//   clk, clr_n                 clock, asynchronous active-low reset
//   start, k_len, busy         job start (IDLE only), job length K, job in progress
//   in_valid, in_ready         operand pair handshake (FEED only)
//   a_vec, b_vec               A column k / B row k, slice i = element i
//   arr_a, arr_b               skewed operands to array A0..A4 / B0..B4
//   arr_clr/read/write         array mode vectors, bit 5*row+col
//   arr_bout                   array B0_out..B4_out
//   res_valid, res_row,        result row strobe, its row index (4..0),
//   res_vec, done              result data (arr_bout), pulse with last row
module systolic_ctrl
  import systolic_pkg::*;
#(
  parameter int N  = 32,
  parameter int KW = 8
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic [KW-1:0]     k_len,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIM*N-1:0]  a_vec,
  input  logic [DIM*N-1:0]  b_vec,
  output logic [DIM*N-1:0]  arr_a,
  output logic [DIM*N-1:0]  arr_b,
  output logic [MODE_W-1:0] arr_clr,
  output logic [MODE_W-1:0] arr_read,
  output logic [MODE_W-1:0] arr_write,
  input  logic [DIM*N-1:0]  arr_bout,
  output logic              res_valid,
  output logic [2:0]        res_row,
  output logic [DIM*N-1:0]  res_vec,
  output logic              done
);

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [3:0]    phase_q, phase_d;
  logic          hs;
  logic [DIM*N-1:0] a_push, b_push;

  assign hs = (state_q == ST_FEED) && in_valid;

  // Phase counter restarts at 0 on every state change; only FLUSH and
  // SHIFT advance it.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    phase_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          k_d     = k_len;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = (k_q == '0) ? ST_READ : ST_FEED;
      ST_FEED: begin
        if (hs) begin
          k_d = k_q - 1'b1;
          if (k_q == KW'(1)) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (phase_q == 4'(FLUSH_CYCLES - 1)) state_d = ST_READ;
        else                                 phase_d = phase_q + 4'd1;
      end
      ST_READ: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (phase_q == 4'(SHIFT_CYCLES - 1)) state_d = ST_DONE;
        else                                 phase_d = phase_q + 4'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      phase_q <= phase_d;
    end
  end

  // Outside a handshake the skew lines are fed zeros, which the array
  // accumulates as a harmless zero k-step.
  assign a_push = hs ? a_vec : '0;
  assign b_push = hs ? b_vec : '0;

  // Row/column g sees its operand g+1 cycles after the handshake, so the
  // A and B wavefronts meet at PE(r,c) on the same cycle.
  for (genvar g = 0; g < DIM; g++) begin : g_skew
    skew_line #(.DEPTH(g + 1), .N(N)) u_skew_a (
      .clk    (clk),
      .clr_n  (clr_n),
      .en_i   (1'b1),
      .din_i  (a_push[g*N +: N]),
      .dout_o (arr_a[g*N +: N])
    );
    skew_line #(.DEPTH(g + 1), .N(N)) u_skew_b (
      .clk    (clk),
      .clr_n  (clr_n),
      .en_i   (1'b1),
      .din_i  (b_push[g*N +: N]),
      .dout_o (arr_b[g*N +: N])
    );
  end

  assign arr_clr   = {MODE_W{state_q == ST_CLEAR}};
  assign arr_read  = {MODE_W{state_q == ST_READ}};
  assign arr_write = {MODE_W{state_q == ST_SHIFT}};

  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_FEED);
  assign done      = (state_q == ST_DONE);

  // Bottom row appears right after READ; each SHIFT brings the next row up.
  assign res_valid = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign res_row   = (state_q == ST_SHIFT) ? (3'(DIM - 1) - phase_q[2:0]) : 3'd0;
  assign res_vec   = arr_bout;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb/tb_systolic_ctrl.sv - self-checking bench for systolic_ctrl with a behavioural 5x5 array
module tb_systolic_ctrl;

  localparam int N = 32;

  logic         clk;
  logic         clr_n;
  logic         start;
  logic [7:0]   k_len;
  logic         busy;
  logic         in_valid;
  logic         in_ready;
  logic [159:0] a_vec, b_vec;
  logic [159:0] arr_a, arr_b;
  logic [24:0]  arr_clr, arr_read, arr_write;
  logic [159:0] arr_bout;
  logic         res_valid;
  logic [2:0]   res_row;
  logic [159:0] res_vec;
  logic         done;

  systolic_ctrl #(.N(N), .KW(8)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .start     (start),
    .k_len     (k_len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_vec     (a_vec),
    .b_vec     (b_vec),
    .arr_a     (arr_a),
    .arr_b     (arr_b),
    .arr_clr   (arr_clr),
    .arr_read  (arr_read),
    .arr_write (arr_write),
    .arr_bout  (arr_bout),
    .res_valid (res_valid),
    .res_row   (res_row),
    .res_vec   (res_vec),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural output-stationary array: clr > read > write > accumulate.
  logic [31:0] acc_m [5][5];
  logic [31:0] ao_m  [5][5];
  logic [31:0] bo_m  [5][5];
  logic [31:0] ain_m [5][5];
  logic [31:0] bin_m [5][5];

  always_comb begin
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        ain_m[r][c] = (c == 0) ? arr_a[r*32 +: 32] : ao_m[r][(c == 0) ? 0 : c-1];
        bin_m[r][c] = (r == 0) ? arr_b[c*32 +: 32] : bo_m[(r == 0) ? 0 : r-1][c];
      end
    end
  end

  always @(posedge clk) begin
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        if (arr_clr[5*r+c]) begin
          acc_m[r][c] <= '0;
          ao_m[r][c]  <= '0;
          bo_m[r][c]  <= '0;
        end else if (arr_read[5*r+c]) begin
          bo_m[r][c]  <= acc_m[r][c];
        end else if (arr_write[5*r+c]) begin
          bo_m[r][c]  <= bin_m[r][c];
        end else begin
          acc_m[r][c] <= acc_m[r][c] + ain_m[r][c] * bin_m[r][c];
          ao_m[r][c]  <= ain_m[r][c];
          bo_m[r][c]  <= bin_m[r][c];
        end
      end
    end
  end

  always_comb begin
    arr_bout = '0;
    for (int c = 0; c < 5; c++) arr_bout[c*32 +: 32] = bo_m[4][c];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  typedef struct packed {
    logic [2:0]   row;
    logic [159:0] vec;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] a_op [16][5];
  logic [31:0] b_op [16][5];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          fail_cnt = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_ops(input int k, input logic [31:0] av, input logic [31:0] bv);
    for (int kk = 0; kk < k; kk++)
      for (int i = 0; i < 5; i++) begin
        a_op[kk][i] = av;
        b_op[kk][i] = bv;
      end
  endtask

  // Runs one job starting at the current negedge; bubble_at = -1 for none.
  task automatic run_job(input int k, input int bubble_at, input int nbub, input bit pulse_busy);
    int           s, fed, bub, guard, done0, exp_done;
    bit           hs;
    logic [24:0]  prev_read;
    logic [159:0] vec;
    logic [31:0]  sum;
    exp_t         e;

    for (int i = 4; i >= 0; i--) begin
      vec = '0;
      for (int j = 0; j < 5; j++) begin
        sum = '0;
        for (int kk = 0; kk < k; kk++) sum = sum + a_op[kk][i] * b_op[kk][j];
        vec[j*32 +: 32] = sum;
      end
      e.row = 3'(i);
      e.vec = vec;
      sb.push_back(e);
    end
    exp_done = (k == 0) ? 7 : 16 + k + nbub;

    done0 = done_cnt;
    s     = cyc;
    start = 1'b1;
    k_len = 8'(k);
    @(negedge clk);
    start = 1'b0;
    chk("clear_mode", {135'd0, arr_clr}, {135'd0, {25{1'b1}}});
    chk("clear_busy", {159'd0, busy}, {159'd0, 1'b1});

    fed = 0; bub = 0; guard = 0;
    while (fed < k && guard < 200) begin
      if (fed == bubble_at && bub < nbub && in_ready) begin
        in_valid = 1'b0;
        bub++;
      end else begin
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
          a_vec[i*32 +: 32] = a_op[fed][i];
          b_vec[i*32 +: 32] = b_op[fed][i];
        end
      end
      hs = in_ready && in_valid;
      @(negedge clk);
      if (hs) fed++;
      guard++;
    end
    chk("feed_count", 160'(fed), 160'(k));
    in_valid = 1'b0;
    a_vec = '0;
    b_vec = '0;
    if (k > 0) chk("flush_ready", {159'd0, in_ready}, 160'd0);

    if (pulse_busy) begin
      start = 1'b1;
      k_len = 8'd7;
      @(negedge clk);
      start = 1'b0;
    end

    guard = 0;
    prev_read = '0;
    while (!res_valid && guard < 60) begin
      prev_read = arr_read;
      @(negedge clk);
      guard++;
    end
    chk("res_valid_seen", {159'd0, res_valid}, {159'd0, 1'b1});
    chk("read_mode", {135'd0, prev_read}, {135'd0, {25{1'b1}}});

    for (int r = 0; r < 5; r++) begin
      chk("sb_nonempty", {159'd0, sb.size() != 0}, {159'd0, 1'b1});
      e = (sb.size() != 0) ? sb.pop_front() : '0;
      chk("res_valid", {159'd0, res_valid}, {159'd0, 1'b1});
      chk("res_row", {157'd0, res_row}, {157'd0, e.row});
      chk("res_vec", res_vec, e.vec);
      chk("done_pulse", {159'd0, done}, {159'd0, r == 4});
      chk("write_mode", {135'd0, arr_write}, {135'd0, (r < 4) ? {25{1'b1}} : 25'd0});
      if (r == 4) chk("done_cycle", 160'(cyc), 160'(s + exp_done));
      else @(negedge clk);
    end
    @(negedge clk);
    chk("idle_busy", {159'd0, busy}, 160'd0);
    chk("idle_res_valid", {159'd0, res_valid}, 160'd0);
    chk("done_count", 160'(done_cnt - done0), 160'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    clr_n    = 1'b0;
    start    = 1'b0;
    k_len    = '0;
    in_valid = 1'b0;
    a_vec    = '0;
    b_vec    = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {159'd0, busy}, 160'd0);
    chk("rst_in_ready", {159'd0, in_ready}, 160'd0);
    chk("rst_res_valid", {159'd0, res_valid}, 160'd0);
    chk("rst_done", {159'd0, done}, 160'd0);
    chk("rst_res_row", {157'd0, res_row}, 160'd0);
    chk("rst_arr_a", arr_a, 160'd0);
    chk("rst_arr_b", arr_b, 160'd0);
    chk("rst_modes", {85'd0, arr_clr, arr_read, arr_write}, 160'd0);
    clr_n = 1'b1;
    @(negedge clk);

    // Identity: A = I, B[k][j] = 10k+j -> C = B.
    for (int kk = 0; kk < 5; kk++)
      for (int i = 0; i < 5; i++) begin
        a_op[kk][i] = (i == kk) ? 32'd1 : 32'd0;
        b_op[kk][i] = 32'(10 * kk + i);
      end
    run_job(5, -1, 0, 1'b0);

    // Ones: K=3, all elements 2 -> 12.
    fill_ops(3, 32'd2, 32'd2);
    run_job(3, -1, 0, 1'b0);

    // Same job with two bubbles after the first handshake.
    run_job(3, 1, 2, 1'b0);

    // K=0, then back-to-back K=1 job with A=B=3.
    run_job(0, -1, 0, 1'b0);
    fill_ops(1, 32'd3, 32'd3);
    run_job(1, -1, 0, 1'b0);

    // Reset in the middle of FEED.
    d0 = done_cnt;
    fill_ops(4, 32'd2, 32'd5);
    start = 1'b1;
    k_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    a_vec = {5{32'd2}};
    b_vec = {5{32'd5}};
    repeat (3) @(negedge clk);
    clr_n = 1'b0;
    #1;
    chk("abort_busy", {159'd0, busy}, 160'd0);
    chk("abort_in_ready", {159'd0, in_ready}, 160'd0);
    chk("abort_arr_a", arr_a, 160'd0);
    chk("abort_arr_b", arr_b, 160'd0);
    chk("abort_modes", {85'd0, arr_clr, arr_read, arr_write}, 160'd0);
    @(negedge clk);
    clr_n = 1'b1;
    in_valid = 1'b0;
    a_vec = '0;
    b_vec = '0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 160'(done_cnt - d0), 160'd0);
    chk("abort_idle", {159'd0, busy}, 160'd0);
    fill_ops(3, 32'd2, 32'd2);
    run_job(3, -1, 0, 1'b0);

    // Wrap: 0x10000 * 0x10000 = 0 mod 2^32; start during busy is ignored.
    fill_ops(1, 32'h0001_0000, 32'h0001_0000);
    run_job(1, -1, 0, 1'b1);
    d0 = done_cnt;
    repeat (3) @(negedge clk);
    chk("ignored_start_busy", {159'd0, busy}, 160'd0);
    chk("ignored_start_done", 160'(done_cnt - d0), 160'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
